// File: rtl/qspi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qspi_target_pkg
// Purpose  : Command codes, phase lengths and FSM encoding shared with the initiator.
// Revision : 1.0
// ============================================================================

package qspi_target_pkg;

    localparam logic [7:0] c_cmd_rd = 8'hEB;
    localparam logic [7:0] c_cmd_wr = 8'h38;
    localparam logic [3:0] c_addr_n = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } qspi_state_t;

endpackage

`default_nettype wire

// File: rtl/qspi_target.sv
`default_nettype none
// ============================================================================
// Module   : qspi_target
// Purpose  : QPI read/write responder serving a byte-wide synchronous RAM port.
// Revision : 1.0
// ============================================================================

module qspi_target
    import qspi_target_pkg::*;
#(
    parameter int         AW     = 16,
    parameter int         DUMMY  = 6,
    parameter logic [7:0] CMD_RD = c_cmd_rd,
    parameter logic [7:0] CMD_WR = c_cmd_wr
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_n,
    input  logic [3:0]    qspi_in,
    output logic [3:0]    qspi_out,
    output logic [3:0]    qspi_oe,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);

    qspi_state_t r_state;
    qspi_state_t w_state_nxt;
    logic [3:0]  r_cnt;
    logic [23:0] r_addr;
    logic [3:0]  r_cmd_hi;
    logic        r_is_rd;
    logic [7:0]  r_data;
    logic [3:0]  r_nib;
    logic        r_lo;
    logic [7:0]  w_cmd;
    logic        w_stay;
    logic        w_drive;

    assign w_cmd  = {r_cmd_hi, qspi_in};
    assign w_stay = (w_state_nxt == r_state);
    assign busy   = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_drive     = (r_state == ST_RDATA);
        qspi_oe     = {4{w_drive}};
        qspi_out    = 4'h0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 8'h00;
        mem_addr    = r_addr[AW-1:0];

        if (w_drive) begin
            qspi_out = r_lo ? r_data[3:0] : r_data[7:4];
        end

        if (cs_n) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_CMD;
                ST_CMD:   w_state_nxt = (w_cmd == CMD_RD || w_cmd == CMD_WR) ? ST_ADDR : ST_IGNORE;
                ST_ADDR: begin
                    if (r_cnt == c_addr_n - 4'd1) begin
                        w_state_nxt = r_is_rd ? ST_DUMMY : ST_WDATA;
                    end
                end
                ST_DUMMY: begin
                    mem_re = (r_cnt == 4'd0);
                    if (r_cnt == 4'(DUMMY - 1)) begin
                        w_state_nxt = ST_RDATA;
                    end
                end
                // Fetch the next byte while the high nibble of the current one is on the bus.
                ST_RDATA: begin
                    if (!r_lo) begin
                        mem_re   = 1'b1;
                        mem_addr = r_addr[AW-1:0] + AW'(1);
                    end
                end
                ST_WDATA: begin
                    if (r_lo) begin
                        mem_we    = 1'b1;
                        mem_wdata = {r_nib, qspi_in};
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 24'd0;
            r_cmd_hi <= 4'd0;
            r_is_rd  <= 1'b0;
            r_data   <= 8'h00;
            r_nib    <= 4'd0;
            r_lo     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_stay ? r_cnt + 4'd1 : 4'd0;
            r_lo    <= w_stay ? ~r_lo : 1'b0;
            if (!cs_n) begin
                case (r_state)
                    ST_IDLE:  r_cmd_hi <= qspi_in;
                    ST_CMD:   r_is_rd  <= (w_cmd == CMD_RD);
                    ST_ADDR:  r_addr   <= {r_addr[19:0], qspi_in};
                    ST_DUMMY: begin
                        if (r_cnt == 4'd1) begin
                            r_data <= mem_rdata;
                        end
                    end
                    ST_RDATA: begin
                        if (r_lo) begin
                            r_data <= mem_rdata;
                            r_addr <= r_addr + 24'd1;
                        end
                    end
                    ST_WDATA: begin
                        if (r_lo) begin
                            r_addr <= r_addr + 24'd1;
                        end else begin
                            r_nib <= qspi_in;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire
